// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller for an NCO: steps a registered tuning word from start to stop,
// holding each word for a programmable dwell. Optional triangle sweep: NCO_SWEEP_TRIANGLE_EN.
module nco_sweep_ctrl #(
   parameter int unsigned FREQ_W  = 8,
   parameter int unsigned DWELL_W = 21
) (
   input  logic               pll_clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic               continuous_i,
   input  logic               tri_i,
   input  logic [FREQ_W-1:0]  start_word_i,
   input  logic [FREQ_W-1:0]  stop_word_i,
   input  logic [FREQ_W-1:0]  step_word_i,
   input  logic [DWELL_W-1:0] dwell_cycles_i,
   output logic [FREQ_W-1:0]  freq_word_o,
   output logic               busy_o,
   output logic               step_strobe_o,
   output logic               done_o
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e               state_q, state_d;
   logic [FREQ_W-1:0]    freq_q, freq_d;
   logic                 busy_q, busy_d;
   logic                 strobe_q, strobe_d;
   logic                 done_q, done_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [FREQ_W-1:0]    start_q, start_d;
   logic [FREQ_W-1:0]    stop_q, stop_d;
   logic [FREQ_W-1:0]    step_q, step_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic                 cont_q, cont_d;

   logic [FREQ_W:0]      sum_up;
   logic                 up_ok;
   logic [DWELL_W-1:0]   dwell_end;
   logic                 dwell_hit;
   logic                 limit;

   // Extra MSB catches the carry so a wrap past all-ones is seen as a limit, not a small word.
   assign sum_up    = {1'b0, freq_q} + {1'b0, step_q};
   assign up_ok     = !sum_up[FREQ_W] && (sum_up[FREQ_W-1:0] <= stop_q) && (step_q != '0);
   assign dwell_end = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
   assign dwell_hit = (cnt_q == dwell_end);

`ifdef NCO_SWEEP_TRIANGLE_EN
   logic                 tri_q, tri_d;
   logic                 dir_q, dir_d;   // 1: descending
   logic [FREQ_W:0]      diff_dn;
   logic                 dn_ok;

   assign diff_dn = {1'b0, freq_q} - {1'b0, step_q};
   assign dn_ok   = !diff_dn[FREQ_W] && (diff_dn[FREQ_W-1:0] >= start_q) && (step_q != '0);
`else
   logic                 unused_tri;
   assign unused_tri = tri_i;
`endif

   always_comb begin
      state_d  = state_q;
      freq_d   = freq_q;
      busy_d   = busy_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      start_d  = start_q;
      stop_d   = stop_q;
      step_d   = step_q;
      dwell_d  = dwell_q;
      cont_d   = cont_q;
      limit    = 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
      tri_d    = tri_q;
      dir_d    = dir_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (start_i && !abort_i) begin
               start_d = start_word_i;
               stop_d  = stop_word_i;
               step_d  = step_word_i;
               dwell_d = dwell_cycles_i;
               cont_d  = continuous_i;
               freq_d  = start_word_i;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = StRun;
`ifdef NCO_SWEEP_TRIANGLE_EN
               tri_d   = tri_i;
               dir_d   = 1'b0;
`endif
            end
         end

         StRun: begin
            if (abort_i) begin
               // Abort wins over any step or limit due on this edge.
               state_d = StIdle;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (!dwell_hit) begin
               cnt_d = cnt_q + DWELL_W'(1);
            end else begin
               cnt_d = '0;
`ifdef NCO_SWEEP_TRIANGLE_EN
               if (dir_q) begin
                  if (dn_ok) begin
                     freq_d   = diff_dn[FREQ_W-1:0];
                     strobe_d = 1'b1;
                  end else if (cont_q) begin
                     // Bottom turnaround: skip the endpoint just visited.
                     dir_d    = 1'b0;
                     freq_d   = up_ok ? sum_up[FREQ_W-1:0] : start_q;
                     strobe_d = 1'b1;
                  end else begin
                     limit = 1'b1;
                  end
               end else if (up_ok) begin
                  freq_d   = sum_up[FREQ_W-1:0];
                  strobe_d = 1'b1;
               end else if (tri_q && dn_ok) begin
                  dir_d    = 1'b1;
                  freq_d   = diff_dn[FREQ_W-1:0];
                  strobe_d = 1'b1;
               end else begin
                  limit = 1'b1;
               end
`else
               if (up_ok) begin
                  freq_d   = sum_up[FREQ_W-1:0];
                  strobe_d = 1'b1;
               end else begin
                  limit = 1'b1;
               end
`endif
            end

            if (limit) begin
               if (cont_q) begin
                  freq_d   = start_q;
                  strobe_d = 1'b1;
`ifdef NCO_SWEEP_TRIANGLE_EN
                  dir_d    = 1'b0;
`endif
               end else begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pll_clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         freq_q   <= '0;
         busy_q   <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         start_q  <= '0;
         stop_q   <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         cont_q   <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
         tri_q    <= 1'b0;
         dir_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         freq_q   <= freq_d;
         busy_q   <= busy_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         step_q   <= step_d;
         dwell_q  <= dwell_d;
         cont_q   <= cont_d;
`ifdef NCO_SWEEP_TRIANGLE_EN
         tri_q    <= tri_d;
         dir_q    <= dir_d;
`endif
      end
   end

   assign freq_word_o   = freq_q;
   assign busy_o        = busy_q;
   assign step_strobe_o = strobe_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed literal sweeps plus randomized traffic checked every cycle
// against a timeline model built from the sweep rules (honours NCO_SWEEP_TRIANGLE_EN).
module tb_nco_sweep_ctrl;

   localparam int FREQ_W  = 8;
   localparam int DWELL_W = 21;
   localparam int MAXW    = (1 << FREQ_W) - 1;

   logic               clk = 1'b0;
   logic               rst;
   logic               start, abort, cont, tri_sel;
   logic [FREQ_W-1:0]  sw, pw, tw;
   logic [DWELL_W-1:0] dw;
   logic [FREQ_W-1:0]  freq;
   logic               busy, strobe, done;

   int n_checks = 0;
   int n_fail   = 0;

   nco_sweep_ctrl #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W)) dut (
      .pll_clock_i   (clk),
      .reset_i       (rst),
      .start_i       (start),
      .abort_i       (abort),
      .continuous_i  (cont),
      .tri_i         (tri_sel),
      .start_word_i  (sw),
      .stop_word_i   (pw),
      .step_word_i   (tw),
      .dwell_cycles_i(dw),
      .freq_word_o   (freq),
      .busy_o        (busy),
      .step_strobe_o (strobe),
      .done_o        (done)
   );

   always #5 clk = ~clk;

   // Expected per-cycle outputs for the rest of the current sweep.
   typedef struct {
      logic [7:0] f;
      bit         b;
      bit         s;
      bit         d;
   } entry_t;

   entry_t     tl[$];
   logic [7:0] exp_freq;
   bit         exp_busy, exp_strobe, exp_done;
   int         c_start, c_stop, c_step, c_dwell;
   bit         c_cont, c_tri;
   int         gen_w;
   bit         gen_dir, gen_end, gen_prev;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, expv);
      end
   endtask

   // Advance to the next tuning word; returns 1 when a single sweep is finished.
   function automatic bit next_word();
      int n;
      if (!gen_dir) begin
         n = gen_w + c_step;
         if (c_step != 0 && n <= c_stop && n <= MAXW) begin
            gen_w = n;
            return 1'b0;
         end
`ifdef NCO_SWEEP_TRIANGLE_EN
         if (c_tri && c_step != 0 && gen_w - c_step >= c_start) begin
            gen_w   = gen_w - c_step;
            gen_dir = 1'b1;
            return 1'b0;
         end
`endif
         if (c_cont) begin
            gen_w = c_start;
            return 1'b0;
         end
         return 1'b1;
      end else begin
         n = gen_w - c_step;
         if (n >= c_start) begin
            gen_w = n;
            return 1'b0;
         end
         if (c_cont) begin
            gen_dir = 1'b0;
            if (c_step != 0 && gen_w + c_step <= c_stop && gen_w + c_step <= MAXW)
               gen_w = gen_w + c_step;
            else
               gen_w = c_start;
            return 1'b0;
         end
         return 1'b1;
      end
   endfunction

   task automatic refill();
      entry_t e;
      int     d_eff;
      d_eff = (c_dwell == 0) ? 1 : c_dwell;
      while (tl.size() < 4 && !gen_end) begin
         for (int i = 0; i < d_eff; i++) begin
            e.f = 8'(gen_w); e.b = 1'b1; e.s = (i == 0) && gen_prev; e.d = 1'b0;
            tl.push_back(e);
         end
         gen_prev = 1'b1;
         if (next_word()) begin
            e.f = 8'(gen_w); e.b = 1'b0; e.s = 1'b0; e.d = 1'b1;
            tl.push_back(e);
            gen_end = 1'b1;
         end
      end
   endtask

   task automatic apply(input entry_t e);
      exp_freq = e.f; exp_busy = e.b; exp_strobe = e.s; exp_done = e.d;
   endtask

   task automatic model_reset();
      exp_freq = '0; exp_busy = 0; exp_strobe = 0; exp_done = 0;
      tl.delete();
      gen_end = 1'b1;
   endtask

   task automatic model_update();
      if (rst) begin
         model_reset();
      end else if (exp_busy) begin
         if (abort) begin
            exp_busy = 0; exp_strobe = 0; exp_done = 0;
            tl.delete();
            gen_end = 1'b1;
         end else begin
            refill();
            if (tl.size() > 0) apply(tl.pop_front());
         end
      end else begin
         exp_strobe = 0; exp_done = 0;
         if (start && !abort) begin
            c_start = int'(sw); c_stop = int'(pw); c_step = int'(tw); c_dwell = int'(dw);
            c_cont = cont; c_tri = tri_sel;
            gen_w = c_start; gen_dir = 1'b0; gen_end = 1'b0; gen_prev = 1'b0;
            tl.delete();
            refill();
            apply(tl.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      check("freq", int'(freq), int'(exp_freq));
      check("busy", int'(busy), int'(exp_busy));
      check("strobe", int'(strobe), int'(exp_strobe));
      check("done", int'(done), int'(exp_done));
   end

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic lit(input string name, input int f, input int b, input int s, input int d);
      check({name, ".freq"}, int'(freq), f);
      check({name, ".busy"}, int'(busy), b);
      check({name, ".strobe"}, int'(strobe), s);
      check({name, ".done"}, int'(done), d);
   endtask

   task automatic cfg(input int s0, input int s1, input int st, input int dwl, input bit c,
                      input bit t);
      sw = 8'(s0); pw = 8'(s1); tw = 8'(st); dw = 21'(dwl); cont = c; tri_sel = t;
   endtask

   task automatic garble();
      sw = 8'($urandom); pw = 8'($urandom); tw = 8'($urandom); dw = 21'($urandom);
      cont = 1'($urandom); tri_sel = 1'($urandom);
   endtask

   task automatic rand_inputs();
      sw = 8'($urandom);
      pw = ($urandom % 2 != 0) ? sw + 8'($urandom % 40) : 8'($urandom);
      tw = ($urandom % 2 != 0) ? 8'($urandom % 8) : 8'($urandom);
      dw = 21'($urandom % 4);
      cont = ($urandom % 3) == 0;
      tri_sel = 1'($urandom);
      start = ($urandom % 4) == 0;
      abort = exp_busy ? (($urandom % 60) == 0) : (($urandom % 8) == 0);
   endtask

   initial begin
      rst = 1'b1; start = 0; abort = 0;
      cfg(0, 0, 0, 0, 0, 0);
      model_reset();
      tick(); tick();
      lit("reset", 0, 0, 0, 0);
      rst = 1'b0;
      tick();

      // Single sawtooth 10..14 step 2 dwell 3
      cfg(10, 14, 2, 3, 0, 0);
      start = 1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         start = 0;
         garble();
         lit("single", (k <= 3) ? 10 : (k <= 6) ? 12 : 14, (k < 10) ? 1 : 0,
             (k == 4 || k == 7) ? 1 : 0, (k == 10) ? 1 : 0);
      end
      tick();

      // Continuous, aborted during cycle 12
      cfg(10, 14, 2, 3, 1, 0);
      start = 1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         start = 0;
         garble();
         lit("cont", 10 + 2 * (((k - 1) / 3) % 3), 1, (k == 4 || k == 7 || k == 10) ? 1 : 0, 0);
      end
      abort = 1;
      tick();
      abort = 0;
      lit("abort", 10, 0, 0, 0);
      tick();

      // Carry at the top of the word range
      cfg(250, 255, 4, 1, 0, 0);
      start = 1;
      tick(); start = 0; lit("carry1", 250, 1, 0, 0);
      tick(); lit("carry2", 254, 1, 1, 0);
      tick(); lit("carry3", 254, 0, 0, 1);
      tick();

      // Triangle select
      cfg(10, 14, 2, 1, 0, 1);
      start = 1;
      tick(); start = 0; lit("tri1", 10, 1, 0, 0);
      tick(); lit("tri2", 12, 1, 1, 0);
      tick(); lit("tri3", 14, 1, 1, 0);
`ifdef NCO_SWEEP_TRIANGLE_EN
      tick(); lit("tri4", 12, 1, 1, 0);
      tick(); lit("tri5", 10, 1, 1, 0);
      tick(); lit("tri6", 10, 0, 0, 1);
`else
      tick(); lit("tri4", 14, 0, 0, 1);
`endif
      tick();

      // Reset mid-sweep, then start+abort, then a clean restart
      cfg(10, 14, 2, 3, 0, 0);
      start = 1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         start = 0;
      end
      lit("prerst", 12, 1, 1, 0);
      rst = 1;
      model_reset();
      #1;
      lit("asyncrst", 0, 0, 0, 0);
      tick(); tick();
      rst = 0; start = 1; abort = 1;
      tick();
      lit("startabort", 0, 0, 0, 0);
      abort = 0;
      tick();
      start = 0;
      lit("restart", 10, 1, 0, 0);
      abort = 1;
      tick();
      abort = 0;
      lit("abort2", 10, 0, 0, 0);

      // Randomized traffic, including occasional asynchronous resets
      for (int n = 0; n < 8000; n++) begin
         if ($urandom % 1500 == 0) begin
            rst = 1;
            model_reset();
            tick();
            rst = 0;
         end
         rand_inputs();
         tick();
      end
      start = 0; abort = 1;
      tick();
      abort = 0;
      tick();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 Parameter FREQ_W, default 8: width of NCO frequency/tuning word.
REQ-002 Parameter DWELL_W, default 21: width of dwell counter and dwell_cycles.
REQ-003 pll_clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate sweep; return to IDLE.
REQ-007 continuous  input  1  0 = single sweep, 1 = repeat until abort.
REQ-008 tri  input  1  triangle mode select; effective only per REQ-027.
REQ-009 start_word  input  FREQ_W  first tuning word.
REQ-010 stop_word  input  FREQ_W  upper tuning-word limit, inclusive.
REQ-011 step_word  input  FREQ_W  increment per step.
REQ-012 dwell_cycles  input  DWELL_W  cycles spent on each tuning word.
REQ-013 freq_word  output  FREQ_W  registered tuning word driving the NCO.
REQ-014 busy  output  1  high in RUN.
REQ-015 step_strobe  output  1  one-cycle pulse whenever freq_word changes during RUN.
REQ-016 done  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-017 States: IDLE, RUN; all outputs registered.
REQ-018 IDLE: start=1 and abort=0 at edge N latches start/stop/step/dwell/continuous/tri; from N+1 freq_word=start_word, busy=1, dwell counter=0.
REQ-019 Config inputs ignored outside the start-accept edge; start ignored in RUN.
REQ-020 RUN: dwell counter increments each cycle; at count = max(dwell_cycles,1)-1 counter clears and a step event occurs (dwell_cycles=0 treated as 1).
REQ-021 Step event: next = freq_word + step_word computed in FREQ_W+1 bits; if next <= stop_word with no carry, freq_word<=next, step_strobe=1.
REQ-022 Limit event (carry out or next > stop_word): single mode -> done=1, busy=0, IDLE, freq_word holds last value; continuous mode -> freq_word<=start_word, step_strobe=1, stay in RUN.
REQ-023 step_word=0: treated as limit event at first step (single: done after one dwell; continuous: holds start_word, step_strobe pulses each dwell).
REQ-024 start_word > stop_word: freq_word=start_word for one dwell, then limit event.
REQ-025 abort=1 in RUN: next cycle IDLE, busy=0, no done, no step_strobe, freq_word holds; abort beats a simultaneous step/limit event; abort in IDLE has no effect.

Reset
REQ-026 reset asserted (any time, incl. mid-sweep): immediately state=IDLE, freq_word=0, busy=0, step_strobe=0, done=0, dwell counter=0, latched config=0; first start accepted on first edge after deassertion.

Configuration
REQ-027 Macro NCO_SWEEP_TRIANGLE_EN: when defined and latched tri=1, limit event reverses direction (freq_word -= step_word), descending until next < start_word or borrow, then single mode finishes (done) / continuous mode reverses upward again; endpoints not repeated. Without macro, tri ignored, direction logic absent, sawtooth only.

Verification
REQ-028 start=10, stop=14, step=2, dwell=3, single; start at cycle 0 -> freq 10 cycles 1-3, 12 cycles 4-6, 14 cycles 7-9, done=1 cycle 10, busy=0 cycle 10, step_strobe cycles 4 and 7.
REQ-029 Same, continuous=1 -> sequence 10,12,14,10,12,... each held 3 cycles, no done; abort at cycle 12 -> busy=0 cycle 13, freq_word stays 10.
REQ-030 FREQ_W=8, start=250, stop=255, step=4, dwell=1, single -> 250, 254, then done (carry detected, no wrap to 2).
REQ-031 NCO_SWEEP_TRIANGLE_EN, tri=1, start=10, stop=14, step=2, dwell=1, single -> 10,12,14,12,10, then done; without macro -> 10,12,14, done.
REQ-032 reset pulsed mid-sweep at freq 12 -> freq_word=0, busy=0 immediately; start after release restarts at start_word; start+abort same edge in IDLE -> stays IDLE.
